// File: rtl/udl_cnt_mc.sv
// rtl/udl_cnt_mc.sv - multi-channel up/down loadable counter bank with terminal-count strobe
// Optional sticky OVF/UNF flags with CLR_FLG are built when UDL_CNT_MC_STICKY_EN is defined.
module udl_cnt_mc #(
  parameter int Width = 8,
  parameter int Chans = 4,
  parameter int SAT   = 0,
  parameter int TMR   = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [Chans-1:0]       CE,
  input  logic [Chans-1:0]       L,
  input  logic [Chans-1:0]       UP,
  input  logic [Chans*Width-1:0] D,
  input  logic [Chans*Width-1:0] MAX,
`ifdef UDL_CNT_MC_STICKY_EN
  input  logic [Chans-1:0]       CLR_FLG,
  output logic [Chans-1:0]       OVF,
  output logic [Chans-1:0]       UNF,
`endif
  output logic [Chans*Width-1:0] Q,
  output logic [Chans-1:0]       TC
);

  localparam int CW = Chans * Width;
`ifdef UDL_CNT_MC_STICKY_EN
  localparam int SW = CW + 3 * Chans;
`else
  localparam int SW = CW + Chans;
`endif

  // All state lives in one packed vector so the TMR wrapper triplicates it uniformly.
  logic [SW-1:0]    st_v;
  logic [SW-1:0]    st_n;
  logic [CW-1:0]    q_v;
  logic [CW-1:0]    q_n;
  logic [Chans-1:0] tc_v;
  logic [Chans-1:0] tc_n;

  assign q_v  = st_v[CW-1:0];
  assign tc_v = st_v[CW +: Chans];

`ifdef UDL_CNT_MC_STICKY_EN
  logic [Chans-1:0] ovf_v;
  logic [Chans-1:0] unf_v;
  logic [Chans-1:0] ovf_n;
  logic [Chans-1:0] unf_n;

  assign ovf_v = st_v[CW + Chans +: Chans];
  assign unf_v = st_v[CW + 2 * Chans +: Chans];
`endif

  always_comb begin
    logic [Width-1:0] qi;
    logic [Width-1:0] mi;
    qi   = '0;
    mi   = '0;
    q_n  = q_v;
    tc_n = '0;
`ifdef UDL_CNT_MC_STICKY_EN
    // Clear is applied first so a same-edge boundary event re-sets the flag.
    ovf_n = ovf_v & ~CLR_FLG;
    unf_n = unf_v & ~CLR_FLG;
`endif
    for (int i = 0; i < Chans; i++) begin
      qi = q_v[i*Width +: Width];
      mi = MAX[i*Width +: Width];
      if (L[i]) begin
        q_n[i*Width +: Width] = D[i*Width +: Width];
      end else if (CE[i]) begin
        if (UP[i]) begin
          if (qi >= mi) begin
            q_n[i*Width +: Width] = (SAT != 0) ? mi : '0;
            tc_n[i] = 1'b1;
`ifdef UDL_CNT_MC_STICKY_EN
            ovf_n[i] = 1'b1;
`endif
          end else begin
            q_n[i*Width +: Width] = qi + 1'b1;
          end
        end else begin
          if (qi == '0) begin
            q_n[i*Width +: Width] = (SAT != 0) ? '0 : mi;
            tc_n[i] = 1'b1;
`ifdef UDL_CNT_MC_STICKY_EN
            unf_n[i] = 1'b1;
`endif
          end else if (qi > mi) begin
            // Out-of-range value after a load snaps back into range silently.
            q_n[i*Width +: Width] = mi;
          end else begin
            q_n[i*Width +: Width] = qi - 1'b1;
          end
        end
      end
    end
  end

`ifdef UDL_CNT_MC_STICKY_EN
  assign st_n = {unf_n, ovf_n, tc_n, q_n};
`else
  assign st_n = {tc_n, q_n};
`endif

  generate
    if (TMR != 0) begin : g_tmr
      (* syn_preserve = 1 *) logic [SW-1:0] st0;
      (* syn_preserve = 1 *) logic [SW-1:0] st1;
      (* syn_preserve = 1 *) logic [SW-1:0] st2;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          st0 <= '0;
          st1 <= '0;
          st2 <= '0;
        end else begin
          st0 <= st_n;
          st1 <= st_n;
          st2 <= st_n;
        end
      end

      assign st_v = (st0 & st1) | (st0 & st2) | (st1 & st2);
    end else begin : g_one
      logic [SW-1:0] st0;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) st0 <= '0;
        else     st0 <= st_n;
      end

      assign st_v = st0;
    end
  endgenerate

  assign Q  = q_v;
  assign TC = tc_v;
`ifdef UDL_CNT_MC_STICKY_EN
  assign OVF = ovf_v;
  assign UNF = unf_v;
`endif

endmodule

// File: tb/tb_udl_cnt_mc.sv
// tb/tb_udl_cnt_mc.sv - directed self-checking bench for udl_cnt_mc (wrap, saturate and TMR instances)
module tb_udl_cnt_mc;

`ifdef UDL_CNT_MC_STICKY_EN
  localparam int TSW = 32 + 12;
`else
  localparam int TSW = 32 + 4;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  CE  = '0;
  logic [3:0]  L   = '0;
  logic [3:0]  UP  = '0;
  logic [31:0] D   = '0;
  logic [31:0] MAX = '0;
  logic [31:0] q0, q1, q2;
  logic [3:0]  tc0, tc1, tc2;
`ifdef UDL_CNT_MC_STICKY_EN
  logic [3:0]  CLR_FLG = '0;
  logic [3:0]  ovf0, ovf1, ovf2, unf0, unf1, unf2;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0]    mq, nq;
  logic [3:0]     mtc, ntc;
  logic [8:0]     r;
  logic [TSW-1:0] saved, fv;

  always #5 CLK = ~CLK;

  udl_cnt_mc #(.Width(8), .Chans(4), .SAT(0), .TMR(0)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .L(L), .UP(UP), .D(D), .MAX(MAX),
`ifdef UDL_CNT_MC_STICKY_EN
    .CLR_FLG(CLR_FLG), .OVF(ovf0), .UNF(unf0),
`endif
    .Q(q0), .TC(tc0));

  udl_cnt_mc #(.Width(8), .Chans(4), .SAT(1), .TMR(0)) dut_s (
    .CLK(CLK), .RST(RST), .CE(CE), .L(L), .UP(UP), .D(D), .MAX(MAX),
`ifdef UDL_CNT_MC_STICKY_EN
    .CLR_FLG(CLR_FLG), .OVF(ovf1), .UNF(unf1),
`endif
    .Q(q1), .TC(tc1));

  udl_cnt_mc #(.Width(8), .Chans(4), .SAT(0), .TMR(1)) dut_t (
    .CLK(CLK), .RST(RST), .CE(CE), .L(L), .UP(UP), .D(D), .MAX(MAX),
`ifdef UDL_CNT_MC_STICKY_EN
    .CLR_FLG(CLR_FLG), .OVF(ovf2), .UNF(unf2),
`endif
    .Q(q2), .TC(tc2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Wrap-mode reference for one channel: {tc, q_next}.
  function automatic logic [8:0] mstep(input logic [7:0] q, input logic [7:0] m,
                                       input logic [7:0] d, input logic l,
                                       input logic ce, input logic up);
    if (l)   return {1'b0, d};
    if (!ce) return {1'b0, q};
    if (up)  return (q >= m) ? 9'h100 : {1'b0, q + 8'd1};
    if (q == 8'd0) return {1'b1, m};
    if (q > m)     return {1'b0, m};
    return {1'b0, q - 8'd1};
  endfunction

  initial begin
    logic [7:0] wq  [7];
    logic       wtc [7];
    logic [7:0] sq  [7];
    logic       stc [7];
    logic [7:0] dq  [3];
    logic       dtc [3];
    logic [7:0] dsq [3];
    logic       dstc[3];
    wq  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    wtc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    sq  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5};
    stc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    dq  = '{8'd0, 8'd9, 8'd8};
    dtc = '{1'b0, 1'b1, 1'b0};
    dsq = '{8'd0, 8'd0, 8'd0};
    dstc = '{1'b0, 1'b1, 1'b1};

    // Reset and wrap-up
    UP  = 4'hF;
    MAX = {4{8'd5}};
    tick; tick;
    chk("rst_q", q0, 0);
    chk("rst_tc", tc0, 0);
    RST = 1'b0;
    CE  = 4'b0001;
    tick; tick;
    chk("pre_rst_q", q0[7:0], 2);
    RST = 1'b1;
    #1;
    chk("async_rst_q", q0, 0);
    chk("async_rst_tc", tc0, 0);
    chk("async_rst_q_tmr", q2, 0);
    #1 RST = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick;
      chk("wrap_up_q", q0[7:0], wq[k]);
      chk("wrap_up_tc", tc0, {3'b0, wtc[k]});
      chk("sat_up_q", q1[7:0], sq[k]);
      chk("sat_up_tc", tc1, {3'b0, stc[k]});
      chk("tmr_up_q", q2[7:0], wq[k]);
    end

    // Down wrap and saturate, load wins over count
    MAX = {4{8'd9}};
    D   = 32'd1;
    L   = 4'b0001;
    UP  = 4'b0000;
    tick;
    chk("load1_q", q0[7:0], 1);
    chk("load1_q_sat", q1[7:0], 1);
    chk("load1_tc", tc0, 0);
    L = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("wrap_dn_q", q0[7:0], dq[k]);
      chk("wrap_dn_tc", tc0, {3'b0, dtc[k]});
      chk("sat_dn_q", q1[7:0], dsq[k]);
      chk("sat_dn_tc", tc1, {3'b0, dstc[k]});
    end

    // Out-of-range load
    MAX = {4{8'd10}};
    D   = 32'd200;
    L   = 4'b0001;
    UP  = 4'b0001;
    tick;
    chk("oor_load_q", q0[7:0], 200);
    chk("oor_load_tc", tc0, 0);
    L = 4'b0000;
    tick;
    chk("oor_up_q", q0[7:0], 0);
    chk("oor_up_tc", tc0, 4'b0001);
    chk("oor_up_q_sat", q1[7:0], 10);
    chk("oor_up_tc_sat", tc1, 4'b0001);
    L = 4'b0001;
    tick;
    chk("oor_reload_q", q0[7:0], 200);
    L  = 4'b0000;
    UP = 4'b0000;
    tick;
    chk("oor_dn_q", q0[7:0], 10);
    chk("oor_dn_tc", tc0, 0);
    chk("oor_dn_q_sat", q1[7:0], 10);
    chk("oor_dn_tc_sat", tc1, 0);

    // MAX = 0: every counting edge is a boundary
    MAX = '0;
    D   = '0;
    L   = 4'b0001;
    tick;
    L  = 4'b0000;
    UP = 4'b0001;
    tick;
    chk("max0_up_q", q0[7:0], 0);
    chk("max0_up_tc", tc0, 4'b0001);
    UP = 4'b0000;
    tick;
    chk("max0_dn_q", q0[7:0], 0);
    chk("max0_dn_tc", tc0, 4'b0001);
    chk("max0_dn_tc_sat", tc1, 4'b0001);

    // MAX all-ones, free-running
    MAX = 32'h0000_00FF;
    D   = 32'h0000_00FE;
    L   = 4'b0001;
    tick;
    L  = 4'b0000;
    UP = 4'b0001;
    tick;
    chk("ff_q", q0[7:0], 8'hFF);
    chk("ff_tc", tc0, 0);
    tick;
    chk("ff_wrap_q", q0[7:0], 8'h00);
    chk("ff_wrap_tc", tc0, 4'b0001);

    // TMR single-copy upset
    CE = 4'b0000;
    D  = 32'h0000_0037;
    L  = 4'b0001;
    tick;
    L = 4'b0000;
    chk("tmr_load_q", q2[7:0], 8'h37);
    saved = dut_t.g_tmr.st0;
    fv    = {saved[TSW-1:8], 8'hFF};
    force dut_t.g_tmr.st0 = fv;
    #1;
    chk("tmr_copy_upset", dut_t.g_tmr.st0[7:0], 8'hFF);
    chk("tmr_vote_q", q2[7:0], 8'h37);
    release dut_t.g_tmr.st0;
    tick;
    chk("tmr_after_q", q2[7:0], 8'h37);
    chk("tmr_agree01", dut_t.g_tmr.st0, dut_t.g_tmr.st1);
    chk("tmr_agree12", dut_t.g_tmr.st1, dut_t.g_tmr.st2);

`ifdef UDL_CNT_MC_STICKY_EN
    // Sticky flags
    RST = 1'b1;
    #1 RST = 1'b0;
    chk("flg_rst", {ovf0, unf0}, 0);
    MAX = {4{8'd5}};
    D   = 32'd5;
    L   = 4'b0001;
    CE  = 4'b0001;
    UP  = 4'b0001;
    tick;
    L = 4'b0000;
    tick;
    chk("flg_ovf_q", q0[7:0], 0);
    chk("flg_ovf", ovf0, 4'b0001);
    UP = 4'b0000;
    tick;
    chk("flg_unf_q", q0[7:0], 5);
    chk("flg_ovf_hold", ovf0, 4'b0001);
    chk("flg_unf", unf0, 4'b0001);
    UP      = 4'b0001;
    CLR_FLG = 4'b0001;
    tick;
    chk("flg_setwins_ovf", ovf0, 4'b0001);
    chk("flg_clr_unf", unf0, 4'b0000);
    CE = 4'b0000;
    tick;
    chk("flg_clr_ovf", ovf0, 4'b0000);
    chk("flg_tmr_ovf", ovf2, 4'b0000);
    CLR_FLG = 4'b0000;
`endif

    // Channel independence against the reference model
    CE  = '0;
    L   = '0;
    RST = 1'b1;
    #1 RST = 1'b0;
    mq  = '0;
    mtc = '0;
    MAX = {8'd200, 8'd15, 8'd7, 8'd3};
    for (int n = 0; n < 50; n++) begin
      CE = 4'($urandom);
      UP = 4'($urandom);
      L  = {1'b0, 1'($urandom_range(0, 1)), 2'b00};
      D  = $urandom;
      for (int c = 0; c < 4; c++) begin
        r = mstep(mq[c*8 +: 8], MAX[c*8 +: 8], D[c*8 +: 8], L[c], CE[c], UP[c]);
        nq[c*8 +: 8] = r[7:0];
        ntc[c]       = r[8];
      end
      mq  = nq;
      mtc = ntc;
      tick;
      chk("rand_q", q0, mq);
      chk("rand_tc", tc0, mtc);
      chk("rand_q_tmr", q2, mq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udl_cnt_mc.md
Name: udl_cnt_mc

Overview:
- Multi-channel up/down loadable counter bank with a programmable per-channel terminal value (MAX), selectable wrap or saturate mode, and a registered terminal-count strobe.
- Generalised successor to the single up/down loadable counter; used for event, timeout and sequence counting in DMB control logic.
- Channels are fully independent and share one clock, one reset and the TMR option.

Parameters:
- Width, 8, bits per channel counter.
- Chans, 4, number of independent channels (≥1).
- SAT, 0, 0 = wrap at boundaries, 1 = saturate at boundaries (applies to all channels).
- TMR, 0, 1 = triplicate all state registers and vote outputs; next state is computed from the voted value.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- CE  input  Chans  per-channel count enable.
- L  input  Chans  per-channel synchronous load.
- UP  input  Chans  per-channel direction, 1 = up, 0 = down.
- D  input  Chans*Width  load values; channel i at bits [i*Width +: Width].
- MAX  input  Chans*Width  terminal values, same packing as D.
- Q  output  Chans*Width  counter values, same packing.
- TC  output  Chans  registered terminal-count strobe, one per channel.

Behaviour:
- Reset (RST high, async): every Q = 0, every TC = 0, and sticky flags = 0 if the optional feature is built. Reset overrides any load or count in progress. Counting resumes on the first rising edge after RST falls.
- Per-channel priority each rising edge: L > CE > hold.
  - L=1: Q <= D. This applies even if D > MAX. TC <= 0.
  - L=0, CE=1: count one step (see below).
  - L=0, CE=0: Q holds. TC <= 0.
- Up step (UP=1):
  - If Q >= MAX (at or above top): boundary event. SAT=0 gives Q <= 0. SAT=1 gives Q <= MAX.
  - Otherwise Q <= Q+1.
- Down step (UP=0):
  - If Q == 0: boundary event. SAT=0 gives Q <= MAX. SAT=1 gives Q <= 0.
  - If Q > MAX (after an out-of-range load): Q <= MAX. This is not a boundary event.
  - Otherwise Q <= Q-1.
- TC is high for exactly one cycle, on the cycle after a boundary event; otherwise it is 0. Sustained CE at a saturated boundary keeps TC high for each such cycle.
- MAX is sampled combinationally each edge. A change to MAX takes effect on the next count step, and no resynchronisation is done.
- MAX = 0 is legal: Q stays 0 and every counting edge is a boundary event.
- Arithmetic is modulo 2^Width. MAX = all-ones with SAT=0 behaves as a free-running Width-bit counter.
- Latency: Q and TC both change one clock after the controlling inputs. There is no combinational path from any input to any output.
- TMR=1:
  - Q, TC and the flags are each held in three syn_preserve registers feeding a majority vote.
  - All three copies load the same next state, computed from the voted values, so a single upset self-corrects on the next edge.
  - Port behaviour is identical to TMR=0.

Optional Feature:
- Macro UDL_CNT_MC_STICKY_EN.
- When defined, the block adds:
  - input CLR_FLG [Chans]
  - outputs OVF [Chans] and UNF [Chans]
- OVF is set on an up boundary event and UNF on a down boundary event. Both remain set until CLR_FLG is high at a clock edge or RST is asserted.
- If set and clear occur on the same edge, set wins.
- Flags are cleared by RST and are triplicated when TMR=1.
- When the macro is undefined, these ports and their registers do not exist. All other behaviour is unchanged.

Test Plan:
- Reset and wrap-up: Width=8, MAX=5, SAT=0. Assert RST mid-count → Q=0 and TC=0 immediately. Then CE=1, UP=1 for 7 clocks → Q: 1,2,3,4,5,0,1, with TC high only on the cycle after Q went 5→0.
- Down wrap and saturate: MAX=9, load D=1, CE=1, UP=0. With SAT=0 → Q: 0,9,8 and one TC pulse. With SAT=1 → Q: 0,0,0 and TC high on each cycle after a held count.
- Priority and out-of-range load: L=1, CE=1, D=200, MAX=10 → Q=200, TC=0. Then UP=1 → Q=0 (wrap) with TC. Reload 200 with UP=0 → Q=10 and no TC.
- Channel independence: Chans=4, each channel with different CE, UP and MAX over 50 random cycles → each Q matches its reference model, and channel 2 loads do not disturb channels 0, 1 and 3.
- TMR upset: TMR=1. Force one copy of channel 0 Q to 0xFF for one cycle → Q output unchanged, and all copies agree after the next edge.
- Sticky flags (macro defined): wrap up then wrap down → OVF=1, UNF=1. Then CLR_FLG on the same edge as a new up boundary → OVF stays 1, UNF=0.
